// File: rtl/piso_serial_tx_if.sv
// ----------------------------------------------------------------------------
// piso_serial_tx_if
//   Bundles the load handshake, bit tick and serial-side status of the
//   piso_serial_tx frame transmitter.
//
//   en          bit-rate tick from the producer side
//   load_valid  producer offers din
//   load_ready  transmitter can take a word (only while idle)
//   din         WIDTH-bit word to send
//   sout        registered serial line (idles high)
//   busy        frame in progress (start bit through stop bit)
//   done        one-clock pulse after the stop bit completes
//
//   master : word producer / bench side
//   slave  : transmitter side
// ----------------------------------------------------------------------------
interface piso_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] din;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output en, load_valid, din,
        input  load_ready, sout, busy, done
    );

    modport slave (
        input  en, load_valid, din,
        output load_ready, sout, busy, done
    );
endinterface

// File: rtl/piso_serial_tx.sv
// ----------------------------------------------------------------------------
// piso_serial_tx
//   Parallel-in / serial-out frame transmitter. A word accepted through the
//   valid/ready handshake goes out as: start bit (0), data LSB first, stop
//   bit (1). The line idles high. en is the bit tick; with en low the frame
//   simply stretches.
//
//   clk   rising-edge clock
//   aClr  asynchronous active-high reset, aborts any frame without done
//   tx    slave modport of piso_serial_tx_if (en, load_valid, load_ready,
//         din, sout, busy, done) -- all outputs come straight from flops
// ----------------------------------------------------------------------------
module piso_serial_tx #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                aClr,
    piso_serial_tx_if.slave     tx
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;
    logic             r_ready;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_shreg_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_sout_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic             w_ready_next;

    // State and registered outputs.
    always_ff @(posedge clk or posedge aClr) begin
        if (aClr) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_sout  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_shreg <= w_shreg_next;
            r_cnt   <= w_cnt_next;
            r_sout  <= w_sout_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_ready <= w_ready_next;
        end
    end

    // Next-state logic. The load handshake ignores en; every other transition
    // waits for a tick.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (tx.load_valid) w_state_next = S_START;
            S_START: if (tx.en)         w_state_next = S_DATA;
            S_DATA:  if (tx.en && (r_cnt == LAST_BIT)) w_state_next = S_STOP;
            S_STOP:  if (tx.en)         w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    // Next values of the datapath and output flops. Everything holds unless
    // the current state advances; done is the only self-clearing flop.
    always_comb begin
        w_shreg_next = r_shreg;
        w_cnt_next   = r_cnt;
        w_sout_next  = r_sout;
        w_busy_next  = r_busy;
        w_ready_next = r_ready;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sout_next = 1'b1;
                if (tx.load_valid) begin
                    w_shreg_next = tx.din;
                    w_cnt_next   = '0;
                    w_sout_next  = 1'b0;
                    w_busy_next  = 1'b1;
                    w_ready_next = 1'b0;
                end
            end
            S_START: begin
                if (tx.en) w_sout_next = r_shreg[0];
            end
            S_DATA: begin
                if (tx.en) begin
                    if (r_cnt != LAST_BIT) begin
                        // Present the following bit now; r_shreg[0] then
                        // always holds the bit currently on the line.
                        w_shreg_next = r_shreg >> 1;
                        w_cnt_next   = r_cnt + CW'(1);
                        w_sout_next  = r_shreg[1];
                    end else begin
                        w_sout_next  = 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (tx.en) begin
                    w_busy_next  = 1'b0;
                    w_ready_next = 1'b1;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_sout_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_ready_next = 1'b1;
            end
        endcase
    end

    assign tx.sout       = r_sout;
    assign tx.busy       = r_busy;
    assign tx.done       = r_done;
    assign tx.load_ready = r_ready;

endmodule
